p2s_stream_serializer: RTL and testbench
========================================

# p2s_stream_serializer

Parametrised parallel-to-serial stream converter: accepts DATA_W-bit words on a valid/ready input and emits them as DATA_W/LANE_W consecutive LANE_W-bit beats on a valid/ready output. Beat order (LSB- or MSB-first) is selectable. A one-word holding register lets the next word be accepted while the current one shifts out, so back-to-back words stream with zero idle beats. Sits between word-wide datapath logic and narrow serial links.

## Interface

- DATA_W, 8: parallel word width; must be a multiple of LANE_W.
- LANE_W, 2: serial beat width; 1 <= LANE_W <= DATA_W.
- MSB_FIRST, 0: 0 = least-significant lane first, 1 = most-significant lane first.
- Derived: BEATS = DATA_W/LANE_W; CNT_W = max(1, $clog2(BEATS)).

- clk  in  1  single clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- par_data  in  DATA_W  parallel word, sampled only on input handshake.
- par_valid  in  1  par_data valid.
- par_ready  out  1  = !hold_valid.
- ser_data  out  LANE_W  current beat.
- ser_valid  out  1  = sh_valid.
- ser_ready  in  1  downstream accepts beat.
- ser_last  out  1  ser_valid && beat count == BEATS-1.

## Operation

- Storage: shift register sh_data[DATA_W] + sh_valid + beat count cnt[CNT_W]; holding register hold_data[DATA_W] + hold_valid.
- Input transfer (acc) = par_valid && par_ready. Output transfer (beat) = ser_valid && ser_ready.
- Shifter free (free) = !sh_valid || (beat && cnt == BEATS-1).
- When free: load from hold if hold_valid, else load par_data directly if acc (bypass), else sh_valid <= 0. Any load sets sh_valid=1, cnt=0.
- When beat and not last: cnt <= cnt+1; sh_data shifts by LANE_W (right if MSB_FIRST=0, left if 1).
- Hold: if acc and word not bypassed into shifter, hold_data <= par_data, hold_valid <= 1. If hold moves to shifter without a new acc, hold_valid <= 0. Move-out plus acc in the same cycle: new word enters hold, hold_valid stays 1.
- Beat mapping for beat k: MSB_FIRST=0 -> par_data[k*LANE_W +: LANE_W]; MSB_FIRST=1 -> par_data[DATA_W-1-k*LANE_W -: LANE_W].
- ser_data = low lane (MSB_FIRST=0) or high lane (MSB_FIRST=1) of sh_data.
- Output obeys stream rules: while ser_valid && !ser_ready, ser_data, ser_last and cnt hold stable. ser_valid never drops without a beat.
- BEATS=1: block degenerates to a 2-deep register slice; ser_last=1 on every beat.
- Words delivered strictly in acceptance order; no drop, no duplication.

## Timing

- Reset (rstn low, asynchronous): sh_valid=0, hold_valid=0, cnt=0, sh_data=0, hold_data=0. Outputs: ser_valid=0, ser_last=0, ser_data=0, par_ready=1. Inputs are ignored while rstn is low. Reset mid-word discards all in-flight data; the first word after release starts at beat 0.
- Latency: word accepted in cycle t with shifter free -> beat 0 valid in cycle t+1.
- Throughput: with ser_ready held 1 and par_valid held 1, one beat per cycle, no bubble at word boundaries. par_ready is then low for BEATS-1 of every BEATS cycles once hold fills (steady state: one acceptance per BEATS cycles).
- par_ready is a register output (no combinational path from ser_ready).
- Up to two words resident (shifter + hold); third word is stalled by par_ready=0.

## Test plan

- DATA_W=8, LANE_W=2, MSB_FIRST=0, ser_ready=1; send 8'hB4 once -> beats 0,1,3,2 in cycles t+1..t+4, ser_last only on the 4th, ser_valid=0 at t+5.
- Same with MSB_FIRST=1 -> beats 2,3,1,0, ser_last on beat value 0.
- par_valid held with 8'hA5 then 8'h3C, ser_ready=1 -> 8 consecutive valid beats 1,1,2,2,0,3,3,0, no bubble, ser_last on beats 4 and 8.
- Send 8'hA5, drop ser_ready for 5 cycles after beat 1, offer 8'h3C and 8'hFF -> ser_data stays 1 and cnt holds during stall; 8'h3C goes to hold, par_ready=0 so 8'hFF waits; resumed output is 1,2,2,0,3,3,0,3,3,3,3.
- Assert rstn low asynchronously during beat 2 of 8'hA5 with a word in hold -> ser_valid=0 immediately, par_ready=1; after release send 8'h3C -> beats 0,3,3,0 from beat 0.
- DATA_W=LANE_W=8, ser_ready=1, continuous input 8'h11,8'h22,8'h33 -> one beat per cycle, each with ser_last=1, par_ready constantly 1.

Source files
------------

// File: rtl/p2s_stream_serializer.sv
// p2s_stream_serializer: parallel-to-serial stream converter.
// A DATA_W-bit word taken on the par_* handshake leaves as BEATS consecutive
// LANE_W-bit beats on the ser_* handshake. A one-word holding register lets the
// next word be accepted while the current one shifts out, so consecutive words
// stream without an idle beat between them.
module p2s_stream_serializer #(
    parameter int DATA_W    = 8,
    parameter int LANE_W    = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] par_data,
    input  logic              par_valid,
    output logic              par_ready,
    output logic [LANE_W-1:0] ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last
);

    localparam int BEATS = DATA_W / LANE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    // State registers
    logic [DATA_W-1:0] sh_data_r;
    logic              sh_valid_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] hold_data_r;
    logic              hold_valid_r;
    logic              last_r;

    // Next-state values
    logic [DATA_W-1:0] sh_data_s;
    logic              sh_valid_s;
    logic [CNT_W-1:0]  cnt_s;
    logic [DATA_W-1:0] hold_data_s;
    logic              hold_valid_s;
    logic              last_s;

    // Handshake qualifiers
    logic acc_s;
    logic beat_s;
    logic free_s;

    // Transfers are qualified only by registered state plus the incoming valid/ready.
    always_comb begin
        acc_s  = par_valid && !hold_valid_r;
        beat_s = sh_valid_r && ser_ready;
        free_s = !sh_valid_r || (beat_s && (cnt_r == LAST_CNT));
    end

    // Next-state: reload the shifter when it frees up (hold first, then bypass),
    // otherwise advance one lane per beat; park an accepted word in hold when
    // it cannot go straight into the shifter.
    always_comb begin
        sh_data_s    = sh_data_r;
        sh_valid_s   = sh_valid_r;
        cnt_s        = cnt_r;
        hold_data_s  = hold_data_r;
        hold_valid_s = hold_valid_r;

        if (free_s) begin
            if (hold_valid_r) begin
                sh_data_s  = hold_data_r;
                sh_valid_s = 1'b1;
                cnt_s      = '0;
                if (acc_s) begin
                    hold_data_s  = par_data;
                    hold_valid_s = 1'b1;
                end else begin
                    hold_valid_s = 1'b0;
                end
            end else if (acc_s) begin
                sh_data_s  = par_data;
                sh_valid_s = 1'b1;
                cnt_s      = '0;
            end else begin
                sh_valid_s = 1'b0;
            end
        end else begin
            if (beat_s) begin
                cnt_s = cnt_r + CNT_W'(1);
                if (MSB_FIRST != 0) begin
                    sh_data_s = sh_data_r << LANE_W;
                end else begin
                    sh_data_s = sh_data_r >> LANE_W;
                end
            end else begin
                cnt_s = cnt_r;
            end
            if (acc_s) begin
                hold_data_s  = par_data;
                hold_valid_s = 1'b1;
            end else begin
                hold_valid_s = hold_valid_r;
            end
        end

        last_s = sh_valid_s && (cnt_s == LAST_CNT);
    end

    // State update; asynchronous reset discards any in-flight words.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_data_r    <= '0;
            sh_valid_r   <= 1'b0;
            cnt_r        <= '0;
            hold_data_r  <= '0;
            hold_valid_r <= 1'b0;
            last_r       <= 1'b0;
        end else begin
            sh_data_r    <= sh_data_s;
            sh_valid_r   <= sh_valid_s;
            cnt_r        <= cnt_s;
            hold_data_r  <= hold_data_s;
            hold_valid_r <= hold_valid_s;
            last_r       <= last_s;
        end
    end

    // Outputs come straight from registers; the current beat is the lane at the
    // end of the shifter that the shift direction exposes.
    assign par_ready = !hold_valid_r;
    assign ser_valid = sh_valid_r;
    assign ser_last  = last_r;
    assign ser_data  = (MSB_FIRST != 0) ? sh_data_r[DATA_W-1 -: LANE_W]
                                        : sh_data_r[LANE_W-1:0];

endmodule

// File: tb/tb_p2s_stream_serializer.sv
// Self-checking bench for p2s_stream_serializer: three instances (LSB-first 8/2,
// MSB-first 8/2, and the degenerate 8/8 slice) each with a beat scoreboard.
module tb_p2s_stream_serializer;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic [7:0] pd_a = 8'h00, pd_b = 8'h00, pd_c = 8'h00;
    logic       pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;
    logic       sr_a = 1'b0, sr_b = 1'b0, sr_c = 1'b0;
    logic       pr_a, pr_b, pr_c;
    logic [1:0] sd_a, sd_b;
    logic [7:0] sd_c;
    logic       sv_a, sv_b, sv_c;
    logic       sl_a, sl_b, sl_c;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: bit 8 = expected ser_last, bits 7:0 = expected beat.
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [8:0] q_c[$];

    always #5 clk = ~clk;

    p2s_stream_serializer #(.DATA_W(8), .LANE_W(2), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rstn(rstn), .par_data(pd_a), .par_valid(pv_a), .par_ready(pr_a),
        .ser_data(sd_a), .ser_valid(sv_a), .ser_ready(sr_a), .ser_last(sl_a));

    p2s_stream_serializer #(.DATA_W(8), .LANE_W(2), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rstn(rstn), .par_data(pd_b), .par_valid(pv_b), .par_ready(pr_b),
        .ser_data(sd_b), .ser_valid(sv_b), .ser_ready(sr_b), .ser_last(sl_b));

    p2s_stream_serializer #(.DATA_W(8), .LANE_W(8), .MSB_FIRST(0)) dut_c (
        .clk(clk), .rstn(rstn), .par_data(pd_c), .par_valid(pv_c), .par_ready(pr_c),
        .ser_data(sd_c), .ser_valid(sv_c), .ser_ready(sr_c), .ser_last(sl_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word to instance a and wait (bounded) for it to be taken.
    task automatic send_a(input logic [7:0] w);
        int n;
        pd_a = w;
        pv_a = 1'b1;
        n = 0;
        while (!pr_a && n < 50) begin
            step();
            n++;
        end
        chk("send_a_accept", 32'(pr_a), 32'd1);
        step();
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (sv_a && n < 40) begin
            step();
            n++;
        end
        chk("drain_a_idle", 32'(sv_a), 32'd0);
    endtask

    // Transfers are decided at the next rising edge; record them mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (pv_a && pr_a) begin
                for (int k = 0; k < 4; k++) q_a.push_back({(k == 3), 6'd0, pd_a[2*k +: 2]});
            end
            if (sv_a && sr_a) begin
                chk("a_beat_expected", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    logic [8:0] e;
                    e = q_a.pop_front();
                    chk("a_ser_data", 32'(sd_a), 32'(e[1:0]));
                    chk("a_ser_last", 32'(sl_a), 32'(e[8]));
                end
            end
            if (pv_b && pr_b) begin
                for (int k = 0; k < 4; k++) q_b.push_back({(k == 3), 6'd0, pd_b[7-2*k -: 2]});
            end
            if (sv_b && sr_b) begin
                chk("b_beat_expected", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) begin
                    logic [8:0] e;
                    e = q_b.pop_front();
                    chk("b_ser_data", 32'(sd_b), 32'(e[1:0]));
                    chk("b_ser_last", 32'(sl_b), 32'(e[8]));
                end
            end
            if (pv_c && pr_c) q_c.push_back({1'b1, pd_c});
            if (sv_c && sr_c) begin
                chk("c_beat_expected", 32'(q_c.size() != 0), 32'd1);
                if (q_c.size() != 0) begin
                    logic [8:0] e;
                    e = q_c.pop_front();
                    chk("c_ser_data", 32'(sd_c), 32'(e[7:0]));
                    chk("c_ser_last", 32'(sl_c), 32'(e[8]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ser_valid", 32'(sv_a), 32'd0);
        chk("rst_ser_last", 32'(sl_a), 32'd0);
        chk("rst_ser_data", 32'(sd_a), 32'd0);
        chk("rst_par_ready", 32'(pr_a), 32'd1);
        chk("rst_par_ready_c", 32'(pr_c), 32'd1);
        rstn = 1'b1;
        step();

        // LSB-first single word 8'hB4 -> 0,1,3,2
        sr_a = 1'b1;
        send_a(8'hB4);
        pv_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid", 32'(sv_a), 32'd1);
            chk("t1_last", 32'(sl_a), 32'(k == 3));
            step();
        end
        chk("t1_idle_after", 32'(sv_a), 32'd0);

        // MSB-first single word 8'hB4 -> 2,3,1,0
        sr_b = 1'b1;
        pd_b = 8'hB4;
        pv_b = 1'b1;
        chk("t2_par_ready", 32'(pr_b), 32'd1);
        step();
        pv_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t2_valid", 32'(sv_b), 32'd1);
            chk("t2_last", 32'(sl_b), 32'(k == 3));
            step();
        end
        chk("t2_idle_after", 32'(sv_b), 32'd0);

        // Back-to-back 8'hA5, 8'h3C -> eight beats with no bubble
        send_a(8'hA5);
        chk("t3_valid_first", 32'(sv_a), 32'd1);
        send_a(8'h3C);
        pv_a = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("t3_no_bubble", 32'(sv_a), 32'd1);
            step();
        end
        chk("t3_idle_after", 32'(sv_a), 32'd0);

        // Output stall after beat 1 with 8'h3C parked and 8'h FF blocked
        send_a(8'hA5);
        pv_a = 1'b0;
        step();
        sr_a = 1'b0;
        pd_a = 8'h3C;
        pv_a = 1'b1;
        chk("t4_hold_free", 32'(pr_a), 32'd1);
        step();
        pd_a = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            chk("t4_stall_data", 32'(sd_a), 32'd1);
            chk("t4_stall_valid", 32'(sv_a), 32'd1);
            chk("t4_stall_last", 32'(sl_a), 32'd0);
            chk("t4_par_ready_low", 32'(pr_a), 32'd0);
            step();
        end
        sr_a = 1'b1;
        send_a(8'hFF);
        pv_a = 1'b0;
        drain_a();
        chk("t4_queue_empty", 32'(q_a.size()), 32'd0);

        // Asynchronous reset during beat 2 of 8'hA5 with 8'h3C in hold
        send_a(8'hA5);
        pd_a = 8'h3C;
        step();
        pv_a = 1'b0;
        chk("t5_hold_full", 32'(pr_a), 32'd0);
        step();
        chk("t5_beat2_valid", 32'(sv_a), 32'd1);
        rstn = 1'b0;
        q_a.delete();
        #1;
        chk("t5_rst_valid", 32'(sv_a), 32'd0);
        chk("t5_rst_par_ready", 32'(pr_a), 32'd1);
        chk("t5_rst_data", 32'(sd_a), 32'd0);
        step();
        #2;
        rstn = 1'b1;
        step();
        chk("t5_idle_after_rst", 32'(sv_a), 32'd0);
        send_a(8'h3C);
        pv_a = 1'b0;
        chk("t5_restart_valid", 32'(sv_a), 32'd1);
        chk("t5_restart_beat0", 32'(sd_a), 32'd0);
        drain_a();

        // Degenerate 8/8 slice: one beat per word, always last, par_ready stays 1
        sr_c = 1'b1;
        pv_c = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            pd_c = 8'(k * 8'h11);
            chk("t6_par_ready", 32'(pr_c), 32'd1);
            step();
            chk("t6_valid", 32'(sv_c), 32'd1);
            chk("t6_last", 32'(sl_c), 32'd1);
        end
        pv_c = 1'b0;
        step();
        chk("t6_idle_after", 32'(sv_c), 32'd0);

        step();
        chk("end_q_a", 32'(q_a.size()), 32'd0);
        chk("end_q_b", 32'(q_b.size()), 32'd0);
        chk("end_q_c", 32'(q_c.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
